// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - video mode constant sets and counter widths for vga_timing_gen
package vga_timing_pkg;

  localparam int X_W = 11;  // horizontal counter width, covers H_Total <= 2048
  localparam int Y_W = 10;  // vertical counter width, covers V_Total <= 1024
  localparam int F_W = 8;   // frame counter width

  typedef struct packed {
    int h_total;
    int h_sync;
    int hde_start;
    int hde_end;
    int v_total;
    int v_sync;
    int vde_start;
    int vde_end;
  } vga_mode_t;

  localparam vga_mode_t MODE_DEFAULT   = '{1650, 40, 270, 1270, 800, 5, 34, 784};
  localparam vga_mode_t MODE_800X600_72 = '{1040, 120, 184, 984, 666, 6, 29, 629};
  localparam vga_mode_t MODE_640X480_60 = '{800, 96, 144, 784, 525, 2, 35, 515};

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter, wrap flag, sync/de decode
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   en_i           : pixel enable; all registers hold when 0
//   inc_i          : advance the count on this enabled edge
//   cnt_o          : current position
//   wrap_o         : position is TOTAL-1 (combinational, from the count register)
//   sync_o         : registered sync level, active at SYNC_POL while position < SYNC
//   de_o, zero_o   : registered window / position==0 flags
//   de_nxt_o, zero_nxt_o : the same decodes for the next-state position (for the top to combine)
import vga_timing_pkg::*;

module vga_axis_counter #(
  parameter int   TOTAL    = 1650,
  parameter int   SYNC     = 40,
  parameter int   DE_START = 270,
  parameter int   DE_END   = 1270,
  parameter int   W        = 11,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         sync_o,
  output logic         de_o,
  output logic         zero_o,
  output logic         de_nxt_o,
  output logic         zero_nxt_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  // One extra bit so that DE_END == TOTAL == 2**W is still representable.
  localparam logic [W:0] SYNC_C  = (W+1)'(SYNC);
  localparam logic [W:0] DS_C    = (W+1)'(DE_START);
  localparam logic [W:0] DE_C    = (W+1)'(DE_END);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_q, de_q, zero_q;
  logic         wrap;
  logic         sync_nxt, de_nxt, zero_nxt;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    // Decodes look at the next-state count so they land on the same edge as it.
    sync_nxt = ({1'b0, cnt_d} < SYNC_C);
    de_nxt   = ({1'b0, cnt_d} >= DS_C) && ({1'b0, cnt_d} < DE_C);
    zero_nxt = (cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sync_q <= ~SYNC_POL;
      de_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (en_i) begin
      cnt_q  <= cnt_d;
      sync_q <= sync_nxt ? SYNC_POL : ~SYNC_POL;
      de_q   <= de_nxt;
      zero_q <= zero_nxt;
    end
  end

  assign cnt_o      = cnt_q;
  assign wrap_o     = wrap;
  assign sync_o     = sync_q;
  assign de_o       = de_q;
  assign zero_o     = zero_q;
  assign de_nxt_o   = de_nxt;
  assign zero_nxt_o = zero_nxt;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: position, sync, display enable, frame count
// Ports:
//   vga_clk, rst_n, ce : pixel clock, async active-low reset, pixel enable
//   x_cnt, y_cnt       : raster position
//   hsync, vsync       : sync pulses at HS_POL / VS_POL
//   hsync_de, vsync_de, de : active-window flags
//   line_start, frame_start : one-ce-cycle pulses at x==0 / x==0,y==0
//   frame_cnt          : completed frames mod 256
// All outputs are registers updated on the same enabled edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_Total   = MODE_DEFAULT.h_total,
  parameter int   H_Sync    = MODE_DEFAULT.h_sync,
  parameter int   Hde_start = MODE_DEFAULT.hde_start,
  parameter int   Hde_end   = MODE_DEFAULT.hde_end,
  parameter int   V_Total   = MODE_DEFAULT.v_total,
  parameter int   V_Sync    = MODE_DEFAULT.v_sync,
  parameter int   Vde_start = MODE_DEFAULT.vde_start,
  parameter int   Vde_end   = MODE_DEFAULT.vde_end,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic           vga_clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic [X_W-1:0] x_cnt,
  output logic [Y_W-1:0] y_cnt,
  output logic           hsync,
  output logic           vsync,
  output logic           hsync_de,
  output logic           vsync_de,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [F_W-1:0] frame_cnt
);

  if (!(H_Sync < Hde_start && Hde_start < Hde_end && Hde_end <= H_Total && H_Total <= 2048))
  begin : g_h_illegal
    $error("vga_timing_gen: illegal horizontal timing parameters");
  end
  if (!(V_Sync < Vde_start && Vde_start < Vde_end && Vde_end <= V_Total && V_Total <= 1024))
  begin : g_v_illegal
    $error("vga_timing_gen: illegal vertical timing parameters");
  end

  logic h_wrap, v_wrap;
  logic h_de_nxt, v_de_nxt, h_zero_nxt, v_zero_nxt;
  logic h_zero, v_zero;

  vga_axis_counter #(
    .TOTAL(H_Total), .SYNC(H_Sync), .DE_START(Hde_start), .DE_END(Hde_end),
    .W(X_W), .SYNC_POL(HS_POL)
  ) u_h (
    .clk_i(vga_clk), .rst_n_i(rst_n), .en_i(ce), .inc_i(ce),
    .cnt_o(x_cnt), .wrap_o(h_wrap), .sync_o(hsync), .de_o(hsync_de),
    .zero_o(h_zero), .de_nxt_o(h_de_nxt), .zero_nxt_o(h_zero_nxt)
  );

  // Vertical decode registers refresh on every ce edge (not only at line wrap)
  // so that the first edge after reset already shows the y=0 decodes.
  vga_axis_counter #(
    .TOTAL(V_Total), .SYNC(V_Sync), .DE_START(Vde_start), .DE_END(Vde_end),
    .W(Y_W), .SYNC_POL(VS_POL)
  ) u_v (
    .clk_i(vga_clk), .rst_n_i(rst_n), .en_i(ce), .inc_i(ce & h_wrap),
    .cnt_o(y_cnt), .wrap_o(v_wrap), .sync_o(vsync), .de_o(vsync_de),
    .zero_o(v_zero), .de_nxt_o(v_de_nxt), .zero_nxt_o(v_zero_nxt)
  );

  logic           de_q, frame_start_q;
  logic [F_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (ce && h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (ce) begin
      de_q          <= h_de_nxt & v_de_nxt;
      frame_start_q <= h_zero_nxt & v_zero_nxt;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign de          = de_q;
  assign line_start  = h_zero;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

  logic unused_v_zero;
  assign unused_v_zero = v_zero;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Small raster so full frames and the 256-frame wrap stay short.
  localparam int HT = 12, HS = 2, HDS = 3, HDE = 12;  // de to end of line
  localparam int VT = 6,  VS = 1, VDS = 2, VDE = 5;
  // Active-high polarity instance with a different window.
  localparam int PHS = 3, PHDS = 4, PHDE = 10, PVS = 2, PVDS = 3, PVDE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic [10:0] x_cnt, px_cnt;
  logic [9:0]  y_cnt, py_cnt;
  logic [7:0]  frame_cnt, pframe_cnt;
  logic hsync, vsync, hsync_de, vsync_de, de, line_start, frame_start;
  logic phsync, pvsync, phsync_de, pvsync_de, pde, pline_start, pframe_start;

  vga_timing_gen #(
    .H_Total(HT), .H_Sync(HS), .Hde_start(HDS), .Hde_end(HDE),
    .V_Total(VT), .V_Sync(VS), .Vde_start(VDS), .Vde_end(VDE),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .vga_clk(clk), .rst_n(rst_n), .ce(ce), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .hsync(hsync), .vsync(vsync), .hsync_de(hsync_de), .vsync_de(vsync_de),
    .de(de), .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_Total(HT), .H_Sync(PHS), .Hde_start(PHDS), .Hde_end(PHDE),
    .V_Total(VT), .V_Sync(PVS), .Vde_start(PVDS), .Vde_end(PVDE),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .vga_clk(clk), .rst_n(rst_n), .ce(ce), .x_cnt(px_cnt), .y_cnt(py_cnt),
    .hsync(phsync), .vsync(pvsync), .hsync_de(phsync_de), .vsync_de(pvsync_de),
    .de(pde), .line_start(pline_start), .frame_start(pframe_start), .frame_cnt(pframe_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  string phase = "init";

  // Reference model of the raster position.
  int  mx = 0, my = 0, mf = 0;
  bit  valid = 0;  // 0 until the first ce edge after reset

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h (x=%0d y=%0d)", phase, tag, obs, exp, mx, my);
    end
  endtask

  task automatic check_all();
    bit hd, vd, phd, pvd;
    hd  = valid && mx >= HDS  && mx < HDE;
    vd  = valid && my >= VDS  && my < VDE;
    phd = valid && mx >= PHDS && mx < PHDE;
    pvd = valid && my >= PVDS && my < PVDE;
    chk("x_cnt", 32'(x_cnt), 32'(mx));
    chk("y_cnt", 32'(y_cnt), 32'(my));
    chk("frame_cnt", 32'(frame_cnt), 32'(mf));
    chk("hsync", 32'(hsync), 32'(!(valid && mx < HS)));
    chk("vsync", 32'(vsync), 32'(!(valid && my < VS)));
    chk("hsync_de", 32'(hsync_de), 32'(hd));
    chk("vsync_de", 32'(vsync_de), 32'(vd));
    chk("de", 32'(de), 32'(hd && vd));
    chk("line_start", 32'(line_start), 32'(valid && mx == 0));
    chk("frame_start", 32'(frame_start), 32'(valid && mx == 0 && my == 0));
    chk("p_hsync", 32'(phsync), 32'(valid && mx < PHS));
    chk("p_vsync", 32'(pvsync), 32'(valid && my < PVS));
    chk("p_de", 32'(pde), 32'(phd && pvd));
    chk("p_x_cnt", 32'(px_cnt), 32'(mx));
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mf = 0; valid = 0;
  endtask

  task automatic model_step();
    valid = 1;
    if (mx == HT - 1) begin
      mx = 0;
      if (my == VT - 1) begin
        my = 0;
        mf = (mf + 1) % 256;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
  endtask

  // Drive ce for one clock, sample 1 ns after the edge, check everything.
  task automatic step(input bit ce_val);
    ce = ce_val;
    @(posedge clk);
    #1;
    if (ce_val) model_step();
    check_all();
  endtask

  int n_fs, n_ls;

  initial begin
    // Reset state.
    phase = "reset";
    rst_n = 1'b0; ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("rst_hsync_inactive", 32'(hsync), 32'h1);
    chk("rst_phsync_inactive", 32'(phsync), 32'h0);

    // Release with ce low: nothing moves.
    phase = "ce_low";
    @(negedge clk); rst_n = 1'b1; ce = 1'b0;
    repeat (3) step(1'b0);

    // First enabled edge: x=1, decodes for (1,0).
    phase = "first";
    step(1'b1);
    chk("first_x", 32'(x_cnt), 32'd1);
    chk("first_hsync_active", 32'(hsync), 32'h0);
    chk("first_vsync_active", 32'(vsync), 32'h0);
    chk("first_line_start", 32'(line_start), 32'h0);

    // Rest of one full frame: HT*VT enabled cycles total.
    phase = "frame";
    n_fs = 0; n_ls = 0;
    for (int i = 1; i < HT * VT; i++) begin
      step(1'b1);
      n_fs += int'(frame_start);
      n_ls += int'(line_start);
    end
    chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
    chk("frame_start_end", 32'(frame_start), 32'h1);
    chk("frame_start_count", 32'(n_fs), 32'd1);
    chk("line_start_count", 32'(n_ls), 32'(VT));

    // Alternating ce: outputs move only on enabled edges; one frame = 2*HT*VT clocks.
    phase = "alt_ce";
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(i % 2 == 0);
    end
    chk("alt_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("alt_x", 32'(x_cnt), 32'd0);

    // Async reset mid-frame at x=5, y=3, asserted between edges.
    phase = "mid_reset";
    while (!(mx == 5 && my == 3)) step(1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst_n = 1'b1;
    step(1'b1);
    chk("restart_x", 32'(x_cnt), 32'd1);

    // 256 frames from here: frame_cnt wraps 255 -> 0 on the raster wrap edge.
    phase = "wrap256";
    for (int i = 1; i < 256 * HT * VT - 1; i++) step(1'b1);
    chk("pre_wrap_fc", 32'(frame_cnt), 32'd255);
    chk("pre_wrap_x", 32'(x_cnt), 32'(HT - 1));
    chk("pre_wrap_y", 32'(y_cnt), 32'(VT - 1));
    step(1'b1);
    chk("wrap_fc", 32'(frame_cnt), 32'd0);
    chk("wrap_fs", 32'(frame_start), 32'h1);
    chk("wrap_de", 32'(de), 32'h0);
    repeat (HT * (VDS + 1)) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the test-card / pixel stages: it produces the `x_cnt`/`y_cnt` raster position, sync pulses and display-enable windows that downstream colour generators decode. One instance per video output, clocked by the pixel clock, with optional clock-enable for pixel-rate division. All outputs are registered and mutually aligned, so a consumer sees position, sync and enable for the same pixel on the same edge.

## Interface
- `H_Total`, 1650, pixels per line (counter wraps at `H_Total-1`)
- `H_Sync`, 40, hsync width in pixels, starting at x=0
- `Hde_start`, 270, first active x
- `Hde_end`, 1270, first x after active region
- `V_Total`, 800, lines per frame
- `V_Sync`, 5, vsync width in lines, starting at y=0
- `Vde_start`, 34, first active y
- `Vde_end`, 784, first y after active region
- `HS_POL`, 1'b0, active level of `hsync` (0 = active-low)
- `VS_POL`, 1'b0, active level of `vsync`
- `vga_clk`  in  1  pixel clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ce`  in  1  pixel enable; counters advance only when 1
- `x_cnt`  out  11  horizontal position, 0..H_Total-1
- `y_cnt`  out  10  vertical position, 0..V_Total-1
- `hsync`  out  1  horizontal sync, polarity per `HS_POL`
- `vsync`  out  1  vertical sync, polarity per `VS_POL`
- `hsync_de`  out  1  1 when Hde_start <= x_cnt < Hde_end
- `vsync_de`  out  1  1 when Vde_start <= y_cnt < Vde_end
- `de`  out  1  `hsync_de & vsync_de`
- `line_start`  out  1  1 while x_cnt==0
- `frame_start`  out  1  1 while x_cnt==0 and y_cnt==0
- `frame_cnt`  out  8  frames completed, mod 256

## Operation
- Counters: on `ce`=1, x_cnt increments; at x_cnt==H_Total-1 it wraps to 0 and y_cnt increments; at y_cnt==V_Total-1 with x wrap, y_cnt wraps to 0 and frame_cnt increments (8-bit wrap, 255->0).
- `ce`=0: every output holds its value; no pulse is re-generated or stretched beyond the held cycle.
- Decodes (hsync, vsync, *_de, de, line_start, frame_start) are computed from the next-state counter values and registered, so they are coincident with the x_cnt/y_cnt they describe; no comparator path from output regs to outputs.
- hsync active while x_cnt < H_Sync; vsync active while y_cnt < V_Sync (whole lines, not offset by hsync).
- Compares are unsigned, full counter width; Hde_end==H_Total permitted (de to end of line).
- Parameter legality (elaboration check, `$error`): H_Sync < Hde_start < Hde_end <= H_Total <= 2048; same for V with V_Total <= 1024.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): x_cnt=0, y_cnt=0, frame_cnt=0, hsync=vsync=inactive (i.e. `~HS_POL`, `~VS_POL`), hsync_de=vsync_de=de=0, line_start=frame_start=0.
- First `ce`=1 edge after reset: x_cnt=1, all decodes reflect x=1,y=0 on that same edge; x=0,y=0 state itself is never flagged after reset (frame_start first asserts at start of frame 1).
- Latency counter->decode: 0 cycles (aligned). Pulses `line_start`/`frame_start` are one `ce`-cycle wide.
- Reset mid-frame: outputs return to reset values immediately, independent of `vga_clk`.
- Frame period = H_Total*V_Total enabled cycles; default 1,320,000.

## Structure
- Package `vga_timing_pkg`: mode constant sets (default above, 800x600@72 `1040/120/184/984/666/6/29/629`, 640x480@60 `800/96/144/784/525/2/35/515`) and counter width localparams.
- One sub-module `vga_axis_counter` (count, wrap flag, sync and de window decode with registered look-ahead), instantiated for horizontal (inc=ce) and vertical (inc=ce & h_wrap).

## Test plan
- Reset then 1,320,000 `ce` cycles -> frame_cnt=1, frame_start high exactly once, at x=0,y=0 on the final cycle; line_start count = 800.
- Scan line y=40: hsync low for x=0..39, hsync_de high for x=270..1269 only, de high same range; y=33 and y=784 -> de never high.
- `ce` toggled 1/0 alternately -> all outputs change only on ce=1 edges; frame length 2,640,000 clocks.
- rst_n pulsed low at x=500,y=300 mid-cycle -> outputs at reset values before next edge; count restarts at x=1 on first ce after release.
- HS_POL=1, VS_POL=1 build -> hsync high x=0..39, vsync high y=0..4, idle low, reset value low.
- Run 256 frames -> frame_cnt wraps 255->0 on the x/y wrap edge, no glitch in de.
